// File: rtl/fpdiv_arb.sv
// fpdiv_arb: round-robin scheduler sharing one multi-cycle fp32 div/sqrt unit.
// Ports: req_* (two requesters), du_* (shared datapath), rsp_* (tagged result),
//   busy. Optional macro FPDIV_ARB_FASTPATH_EN: NaN / divide-by-zero bypass.
module fpdiv_arb #(
    parameter int LATENCY = 12,
    parameter int CW      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_op0,
    input  logic [1:0]  req_op1,
    input  logic [1:0]  req_rm,
    input  logic [31:0] req_n0,
    input  logic [31:0] req_d0,
    input  logic [31:0] req_n1,
    input  logic [31:0] req_d1,
    output logic        du_reset,
    output logic [1:0]  du_op,
    output logic        du_rm,
    output logic [31:0] du_n,
    output logic [31:0] du_d,
    input  logic [31:0] du_result,
    output logic        rsp_valid,
    output logic        rsp_tag,
    output logic [31:0] rsp_result,
    input  logic        rsp_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic          rr_ptr;
    logic [CW-1:0] cnt;
    logic          win;
    logic          accept;
    logic          last;
    logic [1:0]    w_op;
    logic          w_rm;
    logic [31:0]   w_n;
    logic [31:0]   w_d;
    logic          fast;
    logic [31:0]   fast_res;

    // Lone requester wins outright; rr_ptr breaks ties.
    assign win    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    assign accept = (state == IDLE) && !reset && (req_valid != 2'b00);
    assign last   = (cnt == CW'(LATENCY - 1));

    assign w_op = win ? req_op1 : req_op0;
    assign w_rm = req_rm[win];
    assign w_n  = win ? req_n1 : req_n0;
    assign w_d  = win ? req_d1 : req_d0;

`ifdef FPDIV_ARB_FASTPATH_EN
    logic n_nan;
    logic d_nan;
    logic d_zero;
    logic n_fin_nz;

    assign n_nan    = (w_n[30:23] == 8'hFF) && (w_n[22:0] != 23'd0);
    assign d_nan    = (w_d[30:23] == 8'hFF) && (w_d[22:0] != 23'd0);
    assign d_zero   = (w_d[30:0] == 31'd0);
    assign n_fin_nz = (w_n[30:23] != 8'hFF) && (w_n[30:0] != 31'd0);

    always_comb begin
        fast     = 1'b0;
        fast_res = 32'd0;
        if (n_nan || d_nan) begin
            fast     = 1'b1;
            fast_res = 32'h7FC00000;
        end else if ((w_op == 2'b00) && d_zero && n_fin_nz) begin
            fast     = 1'b1;
            fast_res = {w_n[31] ^ w_d[31], 31'h7F800000};
        end
    end
`else
    assign fast     = 1'b0;
    assign fast_res = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = fast ? DONE : START;
            START: state_nx = RUN;
            RUN:   if (last) state_nx = DONE;
            DONE:  if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (accept) req_ready = win ? 2'b10 : 2'b01;
        du_reset  = (state != RUN);
        rsp_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= 1'b0;
            cnt        <= '0;
            du_op      <= 2'b00;
            du_rm      <= 1'b0;
            du_n       <= 32'd0;
            du_d       <= 32'd0;
            rsp_tag    <= 1'b0;
            rsp_result <= 32'd0;
        end else begin
            if (accept) begin
                rr_ptr  <= ~win;
                du_op   <= w_op;
                du_rm   <= w_rm;
                du_n    <= w_n;
                du_d    <= w_d;
                rsp_tag <= win;
                if (fast) rsp_result <= fast_res;
            end
            if (state == START)    cnt <= '0;
            else if (state == RUN) cnt <= cnt + 1'b1;
            if ((state == RUN) && last) rsp_result <= du_result;
        end
    end

endmodule

// File: tb/tb_fpdiv_arb.sv
// tb_fpdiv_arb: scoreboard bench for fpdiv_arb with a behavioural datapath
// that only presents a valid result after LATENCY stable cycles.
module tb_fpdiv_arb;

    localparam int LAT = 12;

`ifdef FPDIV_ARB_FASTPATH_EN
    localparam int FP_LAT = 1;
`else
    localparam int FP_LAT = LAT + 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0 = 2'b00;
    logic [1:0]  req_op1 = 2'b00;
    logic [1:0]  req_rm = 2'b00;
    logic [31:0] req_n0 = 32'd0;
    logic [31:0] req_d0 = 32'd0;
    logic [31:0] req_n1 = 32'd0;
    logic [31:0] req_d1 = 32'd0;
    logic        du_reset;
    logic [1:0]  du_op;
    logic        du_rm;
    logic [31:0] du_n;
    logic [31:0] du_d;
    logic [31:0] du_result;
    logic        rsp_valid;
    logic        rsp_tag;
    logic [31:0] rsp_result;
    logic        rsp_ready = 1'b0;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int dp_cnt = 0;

    typedef struct {
        logic        tag;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   g_idx[$];
    int   g_cyc[$];

    fpdiv_arb #(.LATENCY(LAT), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_rm(req_rm),
        .req_n0(req_n0), .req_d0(req_d0), .req_n1(req_n1), .req_d1(req_d1),
        .du_reset(du_reset), .du_op(du_op), .du_rm(du_rm),
        .du_n(du_n), .du_d(du_d), .du_result(du_result),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_result(rsp_result),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in datapath: exact halving for x/2.0, otherwise a mixing function.
    function automatic logic [31:0] dp_func(logic [1:0] op, logic rm,
                                            logic [31:0] n, logic [31:0] d);
        if (op == 2'b00 && d == 32'h40000000) return n - 32'h00800000;
        return n ^ {d[15:0], d[31:16]} ^ {29'd0, rm, op};
    endfunction

    function automatic logic [31:0] exp_result(logic [1:0] op, logic rm,
                                               logic [31:0] n, logic [31:0] d);
`ifdef FPDIV_ARB_FASTPATH_EN
        if ((n[30:23] == 8'hFF && n[22:0] != 0) ||
            (d[30:23] == 8'hFF && d[22:0] != 0)) return 32'h7FC00000;
        if (op == 2'b00 && d[30:0] == 0 && n[30:23] != 8'hFF && n[30:0] != 0)
            return {n[31] ^ d[31], 31'h7F800000};
`endif
        return dp_func(op, rm, n, d);
    endfunction

    always @(posedge clk) begin
        if (du_reset) dp_cnt <= 0;
        else          dp_cnt <= dp_cnt + 1;
    end

    assign du_result = (!du_reset && dp_cnt >= LAT - 1) ?
                       dp_func(du_op, du_rm, du_n, du_d) : 32'hBAD0BAD0;

    // Scoreboard push at every accepted request.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (req_valid & req_ready) != 2'b00) begin
            e.tag = req_ready[1];
            if (e.tag)
                e.res = exp_result(req_op1, req_rm[1], req_n1, req_d1);
            else
                e.res = exp_result(req_op0, req_rm[0], req_n0, req_d0);
            sb.push_back(e);
            g_idx.push_back(int'(e.tag));
            g_cyc.push_back(cyc);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next();
        reset = 1'b1;
        repeat (2) next();
        reset = 1'b0;
        sb.delete();
        g_idx.delete();
        g_cyc.delete();
    endtask

    task automatic wait_rsp(output int got, output bit ok);
        ok  = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok  = 1'b1;
                got = cyc;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_timeout: rsp_valid never rose within 100 cycles");
        end
    endtask

    task automatic test_reset();
        next();
        reset     = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (2) next();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        n_cmp++;
        if ({rsp_valid, rsp_tag, busy, du_reset} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_ctrl: got v/t/b/dr=%b want 0001",
                     {rsp_valid, rsp_tag, busy, du_reset});
        end
        n_cmp++;
        if (rsp_result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rsp_result: got %h want 0", rsp_result);
        end
        n_cmp++;
        if ({du_op, du_rm, du_n, du_d} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_du: got op=%b rm=%b n=%h d=%h want zeros",
                     du_op, du_rm, du_n, du_d);
        end
        next();
        req_valid = 2'b00;
        reset     = 1'b0;
    endtask

    task automatic test_single();
        int t, got;
        bit ok;
        exp_t e;
        do_reset();
        req_op0 = 2'b00; req_rm = 2'b00;
        req_n0 = 32'h3F800000; req_d0 = 32'h40000000;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        t = cyc;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL single_grant: got %b want 01", req_ready);
        end
        next();
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (du_reset !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_start: du_reset=%b busy=%b want 1 1", du_reset, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (du_reset !== 1'b0) begin
            n_err++;
            $display("FAIL single_run_du_reset: got %b want 0", du_reset);
        end
        wait_rsp(got, ok);
        if (ok) begin
            n_cmp++;
            if (got - t != LAT + 2) begin
                n_err++;
                $display("FAIL single_latency: got %0d want %0d", got - t, LAT + 2);
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL single_sb: scoreboard empty at response");
            end else begin
                e = sb.pop_front();
                if (rsp_tag !== e.tag || rsp_result !== e.res) begin
                    n_err++;
                    $display("FAIL single_rsp: got tag=%b res=%h want tag=%b res=%h",
                             rsp_tag, rsp_result, e.tag, e.res);
                end
            end
            n_cmp++;
            if (rsp_result !== 32'h3F000000) begin
                n_err++;
                $display("FAIL single_value: got %h want 3f000000", rsp_result);
            end
        end
        next();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_contention();
        int rtags[$];
        exp_t e;
        next();
        reset = 1'b1;
        req_op0 = 2'b00; req_op1 = 2'b00; req_rm = 2'b10;
        req_n0 = 32'h3F800000; req_d0 = 32'h40000000;
        req_n1 = 32'h40800000; req_d1 = 32'h40000000;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (2) next();
        reset = 1'b0;
        sb.delete(); g_idx.delete(); g_cyc.delete();
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL cont_sb: scoreboard empty at response");
                end else begin
                    e = sb.pop_front();
                    if (rsp_tag !== e.tag || rsp_result !== e.res) begin
                        n_err++;
                        $display("FAIL cont_rsp: got tag=%b res=%h want tag=%b res=%h",
                                 rsp_tag, rsp_result, e.tag, e.res);
                    end
                end
                rtags.push_back(int'(rsp_tag));
            end
            if (rtags.size() >= 4) break;
            next();
        end
        next();
        req_valid = 2'b00;
        n_cmp++;
        if (rtags.size() < 4 || g_idx.size() < 4) begin
            n_err++;
            $display("FAIL cont_count: got %0d grants %0d responses want 4 4",
                     g_idx.size(), rtags.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (g_idx[i] != (i % 2) || rtags[i] != (i % 2)) begin
                    n_err++;
                    $display("FAIL cont_order[%0d]: grant=%0d tag=%0d want %0d",
                             i, g_idx[i], rtags[i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (g_cyc[i] - g_cyc[i-1] != LAT + 3) begin
                    n_err++;
                    $display("FAIL cont_gap[%0d]: got %0d want %0d",
                             i, g_cyc[i] - g_cyc[i-1], LAT + 3);
                end
            end
        end
        repeat (20) next();
    endtask

    task automatic test_backpressure();
        int got;
        bit ok;
        bit stable;
        bit rr_zero;
        logic        tag0;
        logic [31:0] res0;
        exp_t e;
        do_reset();
        req_op0 = 2'b01; req_op1 = 2'b00; req_rm = 2'b01;
        req_n0 = 32'h12345678; req_d0 = 32'h0BADF00D;
        req_n1 = 32'h41000000; req_d1 = 32'h40000000;
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        next();
        req_valid = 2'b10;
        wait_rsp(got, ok);
        tag0 = rsp_tag;
        res0 = rsp_result;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL bp_sb: scoreboard empty at response");
        end else begin
            e = sb.pop_front();
            if (tag0 !== e.tag || res0 !== e.res) begin
                n_err++;
                $display("FAIL bp_rsp: got tag=%b res=%h want tag=%b res=%h",
                         tag0, res0, e.tag, e.res);
            end
        end
        stable  = 1'b1;
        rr_zero = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next();
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_tag !== tag0 || rsp_result !== res0)
                stable = 1'b0;
            if (req_ready !== 2'b00) rr_zero = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_err++;
            $display("FAIL bp_stable: got v=%b tag=%b res=%h want 1 %b %h",
                     rsp_valid, rsp_tag, rsp_result, tag0, res0);
        end
        n_cmp++;
        if (!rr_zero) begin
            n_err++;
            $display("FAIL bp_req_ready: got nonzero want 00 during DONE");
        end
        next();
        rsp_ready = 1'b1;
        @(negedge clk);
        next();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_regrant: got ready=%b rsp_valid=%b want 10 0",
                     req_ready, rsp_valid);
        end
        next();
        req_valid = 2'b00;
        wait_rsp(got, ok);
        if (ok) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL bp_sb2: scoreboard empty at response");
            end else begin
                e = sb.pop_front();
                if (rsp_tag !== e.tag || rsp_result !== e.res) begin
                    n_err++;
                    $display("FAIL bp_rsp2: got tag=%b res=%h want tag=%b res=%h",
                             rsp_tag, rsp_result, e.tag, e.res);
                end
            end
        end
        next();
    endtask

    task automatic test_operand_hold();
        int got;
        bit ok;
        bit held;
        exp_t e;
        do_reset();
        req_op0 = 2'b00; req_rm = 2'b00;
        req_n0 = 32'h3F800000; req_d0 = 32'h40000000;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        next();
        req_valid = 2'b00;
        held = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            req_n0 = $urandom;
            req_d0 = $urandom;
            @(negedge clk);
            if (du_n !== 32'h3F800000 || du_d !== 32'h40000000) held = 1'b0;
            next();
        end
        n_cmp++;
        if (!held) begin
            n_err++;
            $display("FAIL hold_du: got n=%h d=%h want 3f800000 40000000", du_n, du_d);
        end
        wait_rsp(got, ok);
        if (ok) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL hold_sb: scoreboard empty at response");
            end else begin
                e = sb.pop_front();
                if (rsp_result !== e.res || rsp_result !== 32'h3F000000) begin
                    n_err++;
                    $display("FAIL hold_rsp: got %h want %h", rsp_result, e.res);
                end
            end
        end
        next();
    endtask

    task automatic test_mid_reset();
        bit seen;
        do_reset();
        req_op0 = 2'b00; req_rm = 2'b00;
        req_n0 = 32'h40400000; req_d0 = 32'h40000000;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        next();
        req_valid = 2'b00;
        repeat (6) next();
        reset = 1'b1;
        next();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || du_reset !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ctrl: busy=%b rsp_valid=%b du_reset=%b want 0 0 1",
                     busy, rsp_valid, du_reset);
        end
        n_cmp++;
        if (du_n !== 32'd0 || rsp_result !== 32'd0) begin
            n_err++;
            $display("FAIL midrst_data: du_n=%h rsp_result=%h want 0 0", du_n, rsp_result);
        end
        sb.delete();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            next();
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL midrst_stale: got activity after abort want none");
        end
    endtask

    task automatic test_fastpath();
        int t, got;
        bit ok;
        exp_t e;
        do_reset();
        req_op0 = 2'b00; req_rm = 2'b00;
        req_n0 = 32'h40400000; req_d0 = 32'h80000000;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        t = cyc;
        next();
        req_valid = 2'b00;
        wait_rsp(got, ok);
        if (ok) begin
            n_cmp++;
            if (got - t != FP_LAT) begin
                n_err++;
                $display("FAIL fast_latency: got %0d want %0d", got - t, FP_LAT);
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL fast_sb: scoreboard empty at response");
            end else begin
                e = sb.pop_front();
                if (rsp_tag !== e.tag || rsp_result !== e.res) begin
                    n_err++;
                    $display("FAIL fast_rsp: got tag=%b res=%h want tag=%b res=%h",
                             rsp_tag, rsp_result, e.tag, e.res);
                end
            end
        end
        next();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_operand_hold();
        test_mid_reset();
        test_fastpath();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
